sumador_segmentado: RTL and testbench
=====================================

// Module: sumador_segmentado
// PURPOSE
//  Parametrised multi-cycle adder/subtractor, successor to the combinational 32-bit Sumador.
//  Processes WIDTH-bit operands in CHUNK-bit slices, LSB slice first, one slice per clock.
//  Uses a valid/ready handshake on input and output. Reports carry, signed overflow and zero.
//  Sits in the datapath between the register file and the writeback mux.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CHUNK  8   slice width per cycle; must divide WIDTH exactly; NSLICE = WIDTH/CHUNK
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands A, B and resta are valid
//  in_ready   out  1      block accepts a new operation
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  resta      in   1      0: O=A+B; 1: O=A-B
//  O          out  WIDTH  result, registered
//  out_valid  out  1      O and the flags are valid
//  out_ready  in   1      consumer takes the result
//  carry      out  1      carry out of the MSB (on subtract, 1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
//  zero       out  1      raw WIDTH-bit sum == 0
// BEHAVIOUR
//  - One clock (clk). Synchronous active-high reset (rst), sampled on the rising edge of clk.
//  - FSM states: IDLE, BUSY, DONE.
//  - Reset → IDLE. Reset values: O=0, carry=0, overflow=0, zero=0, out_valid=0, slice counter=0.
//    in_ready=1 is decoded from state (IDLE only).
//  - IDLE: in_ready=1. When in_valid&&in_ready on an edge:
//    - latch A;
//    - latch B XOR {WIDTH{resta}};
//    - set the carry register to resta;
//    - set the counter to 0;
//    - move to BUSY.
//  - BUSY: in_ready=0.
//    - Each cycle adds slice[cnt] of both operands plus the carry register.
//    - Writes the CHUNK-bit result into O[cnt*CHUNK +: CHUNK] and updates the carry register.
//    - cnt increments each cycle. On cnt==NSLICE-1 the block sets carry, overflow and zero and moves to DONE.
//  - Latency: out_valid rises exactly NSLICE cycles after the accepting edge (4 cycles for 32/8).
//  - DONE: out_valid=1 and in_ready=0.
//    - O and the flags stay stable until out_valid&&out_ready on an edge; then out_valid=0 and the FSM returns to IDLE.
//    - A new operation is accepted one cycle after the output handshake at the earliest; in_valid during DONE is ignored.
//  - Overflow = (opA[MSB]==opB'[MSB]) && (sum[MSB]!=opA[MSB]), where opB' is B after the XOR.
//  - Arithmetic is modulo 2^WIDTH; the carry is not part of O.
//  - O holds the previous result until it is overwritten slice by slice. O is valid only while out_valid=1.
//  - rst in any state, including mid-BUSY, aborts the operation immediately: the result is discarded and all reset values apply on the next cycle.
//  - in_valid held high with unchanged operands after acceptance does not start a second operation until the FSM is back in IDLE.
// CONFIGURATION
//  SUMADOR_SAT_EN defined:
//    - On signed overflow O saturates: positive overflow → {0,{WIDTH-1{1}}}, negative overflow → {1,{WIDTH-1{0}}}.
//    - overflow still reads 1; zero is computed on the raw sum.
//  SUMADOR_SAT_EN undefined: O wraps, with the overflow flag only. Latency is identical in both builds.
// TESTING  (WIDTH=32, CHUNK=8, out_ready=1 unless stated)
//  1. A=1000, B=1305, resta=0 → O=2305, carry=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
//  2. A=387, B=100, resta=1 → O=287, carry=1, overflow=0; then A=45, B=50, resta=1 → O=0xFFFFFFFB, carry=0.
//  3. A=0xFFFFFFFF, B=1, resta=0 → O=0, carry=1, zero=1, overflow=0 (carry ripples across all 4 slices).
//  4. A=0x7FFFFFFF, B=1 → overflow=1; O=0x80000000 without SUMADOR_SAT_EN, O=0x7FFFFFFF with it.
//  5. Backpressure: A=996, B=4 with out_ready=0 for 5 cycles → O=1000 and out_valid stay stable, in_ready=0.
//     in_valid pulses during this time are ignored. out_ready=1 → IDLE on the next cycle.
//  6. rst=1 on the 2nd BUSY cycle → next cycle: out_valid=0, O=0, flags=0, in_ready=1. A following A=5, B=7 returns O=12.

Source files
------------

// File: rtl/sumador_segmentado.sv
// sumador_segmentado: multi-cycle adder/subtractor working on CHUNK-bit slices,
// LSB slice first, one slice per clock, with valid/ready handshakes on both sides.
// Optional build macro: SUMADOR_SAT_EN -- saturate O on signed overflow.
module sumador_segmentado #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             resta,
    output logic [WIDTH-1:0] O,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;   // B already inverted for subtraction
    logic             cy;     // running carry between slices

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] o_next;
    logic             ovf_next;

`ifdef SUMADOR_SAT_EN
    // Clamp to the most positive / most negative value; the sign of operand A
    // tells the overflow direction, since both operands share it on overflow.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf,
                                                  input logic             a_msb);
        logic signed [WIDTH-1:0] res;
        res = raw;
        if (ovf) res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return res;
    endfunction
`endif

    // Current slice adder and the full result with this slice merged in
    always_comb begin
        slice_sum = {1'b0, op_a[cnt*CHUNK +: CHUNK]}
                  + {1'b0, op_b[cnt*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, cy};
        o_next = O;
        o_next[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (o_next[WIDTH-1] != op_a[WIDTH-1]);
    end

    assign in_ready = (state == IDLE);

    // Control FSM, slice sequencing and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            O         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= A;
                        op_b  <= B ^ {WIDTH{resta}};
                        cy    <= resta;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    O   <= o_next;
                    cy  <= slice_sum[CHUNK];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        carry     <= slice_sum[CHUNK];
                        overflow  <= ovf_next;
                        zero      <= (o_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUMADOR_SAT_EN
                        O         <= saturate(o_next, ovf_next, op_a[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_segmentado.sv
// Self-checking bench for sumador_segmentado (WIDTH=32, CHUNK=8) using a
// scoreboard queue fed by a full-width reference model.
module tb_sumador_segmentado;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        resta;
    logic [31:0] O;
    logic        out_valid;
    logic        out_ready;
    logic        carry;
    logic        overflow;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        cy;
        logic        ovf;
        logic        zr;
    } exp_t;

    exp_t sb[$];

    sumador_segmentado #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .resta(resta), .O(O), .out_valid(out_valid),
        .out_ready(out_ready), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic r);
        exp_t        e;
        logic [31:0] bop;
        logic [32:0] full;
        bop   = r ? ~b : b;
        full  = {1'b0, a} + {1'b0, bop} + {32'd0, r};
        e.cy  = full[32];
        e.ovf = (a[31] == bop[31]) && (full[31] != a[31]);
        e.zr  = (full[31:0] == 32'd0);
        e.o   = full[31:0];
`ifdef SUMADOR_SAT_EN
        if (e.ovf) e.o = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    // One operation: drive, wait for the result, compare, optionally stall the consumer
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic r,
                         input bit keep_valid, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        A = a; B = b; resta = r; in_valid = 1'b1; out_ready = (stall == 0);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sb.push_back(model(a, b, r));
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", lat, 32'd4);
        e = sb.pop_front();
        check("O", O, e.o);
        check("carry", {31'd0, carry}, {31'd0, e.cy});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("zero", {31'd0, zero}, {31'd0, e.zr});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = i[0];
            A = ~a;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_O", O, e.o);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; resta = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_O", O, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'd1000, 32'd1305, 1'b0, 1'b0, 0);
        check("t1_literal", O, 32'd2305);
        do_op(32'd387, 32'd100, 1'b1, 1'b0, 0);
        check("t2a_literal", O, 32'd287);
        do_op(32'd45, 32'd50, 1'b1, 1'b1, 0);
        check("t2b_literal", O, 32'hFFFF_FFFB);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
        check("t3_zero", {31'd0, zero}, 32'd1);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0);
        do_op(32'd996, 32'd4, 1'b0, 1'b0, 5);
        check("t5_literal", O, 32'd1000);

        // Reset on the second BUSY cycle aborts the operation
        @(negedge clk);
        A = 32'h1234_5678; B = 32'h1111_1111; resta = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_O", O, 32'd0);
        check("abort_flags", {29'd0, carry, overflow, zero}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd5, 32'd7, 1'b0, 1'b0, 0);
        check("t6_literal", O, 32'd12);

        for (int k = 0; k < 6; k++) begin
            do_op($urandom, $urandom, k[0], 1'b0, k % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
